config_master: RTL and testbench

- Initiator side of the VGA configuration write interface.
- Turns a user mode request (push button plus 2-bit mode switch) into a single Valid/Addr/Data write to the resolution register of the Config block.
- Waits for the Load_config acknowledge, retries on timeout, and reports Busy/Done/Error.
- Sits between board I/O and Config, inside VGA_Control.

---
 rtl/config_master_pkg.sv | 14 +
 rtl/config_master_btn_conditioner.sv | 32 +++
 rtl/config_master.sv | 74 +++++++
 tb/tb_config_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_master_pkg.sv
// config_master_pkg: shared widths, register address, mode and FSM encodings for config_master
package config_master_pkg;
    localparam int CONFIG_WIDTH = 2;
    localparam int DEBOUNCE_CYCLES = 16;
    typedef logic [CONFIG_WIDTH-1:0] cfg_t;
    localparam cfg_t RES_ADDR = 2'b10;
    localparam cfg_t MODE_6X4 = 2'b00;
    localparam cfg_t MODE_8X6 = 2'b01;
    localparam cfg_t MODE_10X7 = 2'b10;
    localparam cfg_t MODE_RSVD = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
endpackage

// File: rtl/config_master_btn_conditioner.sv
// config_master_btn_conditioner: button synchronizer, optional debounce (CONFIG_MASTER_DEBOUNCE_EN), rising-edge event
module config_master_btn_conditioner
    import config_master_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);
    logic s1, s2, lvl, lvl_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) {s1, s2, lvl_q} <= '0;
        else {s1, s2, lvl_q} <= {btn, s1, lvl};
`ifdef CONFIG_MASTER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic stable;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stable <= 1'b0;
            cnt <= '0;
        end else if (s2 == stable) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
            cnt <= '0;
        end else cnt <= cnt + 1'b1;
    assign lvl = stable;
`else
    assign lvl = s2;
`endif
    assign evt = lvl & ~lvl_q;
endmodule

// File: rtl/config_master.sv
// config_master: issues one resolution-register write per accepted mode request, with ack timeout and retry.
// Build option CONFIG_MASTER_DEBOUNCE_EN adds a debounce filter on the request button.
module config_master
    import config_master_pkg::*;
#(
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_RETRIES = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Req_btn,
    input  logic [CONFIG_WIDTH-1:0] Mode_sel,
    input  logic                    Load_config,
    output logic                    Valid,
    output logic [CONFIG_WIDTH-1:0] Addr,
    output logic [CONFIG_WIDTH-1:0] Data,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error,
    output logic [CONFIG_WIDTH-1:0] Cur_mode
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    logic [1:0] state;
    cfg_t req;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] retry_cnt;
    logic evt;
    config_master_btn_conditioner u_cond (.clk(Clk), .rst(Rst), .btn(Req_btn), .evt(evt));
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            state <= ST_IDLE;
            req <= '0;
            to_cnt <= '0;
            retry_cnt <= '0;
            Done <= 1'b0;
            Error <= 1'b0;
            Cur_mode <= MODE_6X4;
        end else begin
            Done <= 1'b0;
            if (state == ST_IDLE && evt) begin
                req <= Mode_sel;
                if (Mode_sel == MODE_RSVD) Error <= 1'b1;
                else if (Mode_sel != Cur_mode || Error) begin
                    retry_cnt <= '0;
                    state <= ST_ISSUE;
                end
            end else if (state == ST_ISSUE) begin
                to_cnt <= '0;
                state <= ST_WAIT_ACK;
            end else if (state == ST_WAIT_ACK) begin
                to_cnt <= to_cnt + 1'b1;
                // an ack in the final timeout cycle still counts as success
                if (Load_config) begin
                    Cur_mode <= req;
                    Done <= 1'b1;
                    Error <= 1'b0;
                    state <= ST_IDLE;
                end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    if (retry_cnt < RW'(MAX_RETRIES)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state <= ST_ISSUE;
                    end else begin
                        Error <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
            end
        end
    assign Valid = state == ST_ISSUE;
    assign Busy = state != ST_IDLE;
    assign Addr = Busy ? RES_ADDR : '0;
    assign Data = Busy ? req : '0;
endmodule

// File: tb/tb_config_master.sv
// tb_config_master: directed self-checking bench for config_master
module tb_config_master;
`ifdef CONFIG_MASTER_DEBOUNCE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 3;
`endif
    logic clk = 0, rst = 1, req_btn = 0, load_config = 0;
    logic [1:0] mode_sel = 0;
    logic valid, busy, done, error;
    logic [1:0] addr, data, cur_mode;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, vcnt = 0;
    int vcyc[64];

    config_master dut (
        .Clk(clk), .Rst(rst), .Req_btn(req_btn), .Mode_sel(mode_sel), .Load_config(load_config),
        .Valid(valid), .Addr(addr), .Data(data), .Busy(busy), .Done(done), .Error(error), .Cur_mode(cur_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // count Valid pulses mid-low-phase, well clear of the active edge
    always @(negedge clk) begin
        #1;
        if (valid && vcnt < 64) begin
            vcyc[vcnt] = cyc;
            vcnt++;
        end
    end

    task automatic press(input logic [1:0] m);
        @(negedge clk);
        mode_sel = m;
        req_btn = 1;
    endtask

    task automatic release_btn();
        req_btn = 0;
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack_after(input int k);
        repeat (k) @(negedge clk);
        load_config = 1;
        @(negedge clk);
        load_config = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        n_checks += 7;
        if (valid !== 0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        if (addr !== 0) begin n_fail++; $display("FAIL reset_addr got %b want 00", addr); end
        if (data !== 0) begin n_fail++; $display("FAIL reset_data got %b want 00", data); end
        if (busy !== 0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (error !== 0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        if (cur_mode !== 0) begin n_fail++; $display("FAIL reset_cur_mode got %b want 00", cur_mode); end
        rst = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int n, v0;
        v0 = vcnt;
        press(2'b01);
        wait_valid(n);
        n_checks += 4;
        if (n !== LAT) begin n_fail++; $display("FAIL write_latency got %0d want %0d", n, LAT); end
        if (addr !== 2'b10) begin n_fail++; $display("FAIL write_addr got %b want 10", addr); end
        if (data !== 2'b01) begin n_fail++; $display("FAIL write_data got %b want 01", data); end
        if (busy !== 1) begin n_fail++; $display("FAIL write_busy got %b want 1", busy); end
        @(negedge clk);
        n_checks += 3;
        if (valid !== 0) begin n_fail++; $display("FAIL write_valid_width got %b want 0", valid); end
        if (addr !== 2'b10) begin n_fail++; $display("FAIL write_addr_hold got %b want 10", addr); end
        if (data !== 2'b01) begin n_fail++; $display("FAIL write_data_hold got %b want 01", data); end
        ack_after(1);
        n_checks += 6;
        if (done !== 1) begin n_fail++; $display("FAIL write_done got %b want 1", done); end
        if (cur_mode !== 2'b01) begin n_fail++; $display("FAIL write_cur_mode got %b want 01", cur_mode); end
        if (error !== 0) begin n_fail++; $display("FAIL write_error got %b want 0", error); end
        if (busy !== 0) begin n_fail++; $display("FAIL write_busy_after got %b want 0", busy); end
        if (addr !== 0) begin n_fail++; $display("FAIL write_addr_idle got %b want 00", addr); end
        if (data !== 0) begin n_fail++; $display("FAIL write_data_idle got %b want 00", data); end
        @(negedge clk);
        n_checks += 2;
        if (done !== 0) begin n_fail++; $display("FAIL write_done_width got %b want 0", done); end
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL write_pulses got %0d want 1", vcnt - v0); end
        release_btn();
    endtask

    task automatic test_reserved();
        int n, v0;
        v0 = vcnt;
        press(2'b11);
        repeat (LAT + 20) @(negedge clk);
        n_checks += 3;
        if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL rsvd_pulses got %0d want 0", vcnt - v0); end
        if (error !== 1) begin n_fail++; $display("FAIL rsvd_error got %b want 1", error); end
        if (busy !== 0) begin n_fail++; $display("FAIL rsvd_busy got %b want 0", busy); end
        release_btn();
        press(2'b00);
        wait_valid(n);
        n_checks += 2;
        if (n !== LAT) begin n_fail++; $display("FAIL rsvd_reissue_latency got %0d want %0d", n, LAT); end
        if (data !== 2'b00) begin n_fail++; $display("FAIL rsvd_reissue_data got %b want 00", data); end
        ack_after(1);
        n_checks += 3;
        if (done !== 1) begin n_fail++; $display("FAIL rsvd_done got %b want 1", done); end
        if (error !== 0) begin n_fail++; $display("FAIL rsvd_error_clear got %b want 0", error); end
        if (cur_mode !== 2'b00) begin n_fail++; $display("FAIL rsvd_cur_mode got %b want 00", cur_mode); end
        release_btn();
    endtask

    task automatic test_retry();
        int n, v0;
        press(2'b10);
        wait_valid(n);
        v0 = vcnt;
        repeat (40) @(negedge clk);
        n_checks += 6;
        if (vcnt - v0 !== 3) begin n_fail++; $display("FAIL retry_pulses got %0d want 3", vcnt - v0); end
        if (vcyc[v0 + 1] - vcyc[v0] !== 9) begin n_fail++; $display("FAIL retry_gap1 got %0d want 9", vcyc[v0 + 1] - vcyc[v0]); end
        if (vcyc[v0 + 2] - vcyc[v0 + 1] !== 9) begin n_fail++; $display("FAIL retry_gap2 got %0d want 9", vcyc[v0 + 2] - vcyc[v0 + 1]); end
        if (error !== 1) begin n_fail++; $display("FAIL retry_error got %b want 1", error); end
        if (busy !== 0) begin n_fail++; $display("FAIL retry_busy got %b want 0", busy); end
        if (cur_mode !== 2'b00) begin n_fail++; $display("FAIL retry_cur_mode got %b want 00", cur_mode); end
        release_btn();
    endtask

    task automatic test_ack_filter();
        int n, v0;
        v0 = vcnt;
        press(2'b01);
        wait_valid(n);
        load_config = 1;
        @(negedge clk);
        load_config = 0;
        wait_valid(n);
        n_checks += 1;
        if (n !== 8) begin n_fail++; $display("FAIL issue_ack_retry_gap got %0d want 8", n); end
        // acknowledge lands in the last timeout cycle and must win
        ack_after(8);
        n_checks += 3;
        if (done !== 1) begin n_fail++; $display("FAIL edge_ack_done got %b want 1", done); end
        if (cur_mode !== 2'b01) begin n_fail++; $display("FAIL edge_ack_cur_mode got %b want 01", cur_mode); end
        if (error !== 0) begin n_fail++; $display("FAIL edge_ack_error got %b want 0", error); end
        repeat (12) @(negedge clk);
        n_checks += 1;
        if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL edge_ack_pulses got %0d want 2", vcnt - v0); end
        release_btn();
    endtask

    task automatic test_back_to_back();
        int n, v0;
        v0 = vcnt;
        press(2'b10);
        wait_valid(n);
        req_btn = 0;
        @(negedge clk);
        req_btn = 1;
        mode_sel = 2'b00;
        ack_after(5);
        n_checks += 2;
        if (done !== 1) begin n_fail++; $display("FAIL b2b_done got %b want 1", done); end
        if (cur_mode !== 2'b10) begin n_fail++; $display("FAIL b2b_cur_mode got %b want 10", cur_mode); end
        repeat (LAT + 20) @(negedge clk);
        n_checks += 1;
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL b2b_pulses got %0d want 1", vcnt - v0); end
        release_btn();
    endtask

`ifdef CONFIG_MASTER_DEBOUNCE_EN
    task automatic test_debounce();
        int n, v0;
        v0 = vcnt;
        mode_sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            req_btn = 1;
            repeat (5) @(negedge clk);
            req_btn = 0;
            repeat (10) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        n_checks += 1;
        if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d want 0", vcnt - v0); end
        press(2'b00);
        wait_valid(n);
        n_checks += 1;
        if (n !== LAT) begin n_fail++; $display("FAIL debounce_latency got %0d want %0d", n, LAT); end
        ack_after(2);
        req_btn = 0;
        repeat (30) @(negedge clk);
        n_checks += 2;
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL debounce_pulses got %0d want 1", vcnt - v0); end
        if (cur_mode !== 2'b00) begin n_fail++; $display("FAIL debounce_cur_mode got %b want 00", cur_mode); end
    endtask
`endif

    task automatic test_reset_mid();
        int n, v0;
        press(2'b01);
        wait_valid(n);
        @(negedge clk);
        rst = 1;
        #1;
        n_checks += 7;
        if (valid !== 0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", valid); end
        if (busy !== 0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (addr !== 0) begin n_fail++; $display("FAIL midrst_addr got %b want 00", addr); end
        if (data !== 0) begin n_fail++; $display("FAIL midrst_data got %b want 00", data); end
        if (done !== 0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        if (error !== 0) begin n_fail++; $display("FAIL midrst_error got %b want 0", error); end
        if (cur_mode !== 0) begin n_fail++; $display("FAIL midrst_cur_mode got %b want 00", cur_mode); end
        req_btn = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        v0 = vcnt;
        repeat (LAT + 20) @(negedge clk);
        n_checks += 1;
        if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL midrst_pulses got %0d want 0", vcnt - v0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_reserved();
        test_retry();
        test_ack_filter();
        test_back_to_back();
`ifdef CONFIG_MASTER_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
